// File: rtl/serial_word_comparator_if.sv
// Handshake and bit-pair bundle for the bit-serial word comparator.
// The slave side is the comparator; the master side feeds operands and flags.
interface serial_word_comparator_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_bit_a;
  logic             o_bit_b;
  logic             i_yamb;
  logic             i_yarb;
  logic             i_ya_wieksze_b;
  logic             o_busy;
  logic             o_done;
  logic             o_yamb;
  logic             o_yarb;
  logic             o_ya_wieksze_b;
  logic             o_err;

  modport slave (
    input  i_start,
    input  i_a,
    input  i_b,
    output o_bit_a,
    output o_bit_b,
    input  i_yamb,
    input  i_yarb,
    input  i_ya_wieksze_b,
    output o_busy,
    output o_done,
    output o_yamb,
    output o_yarb,
    output o_ya_wieksze_b,
    output o_err
  );

  modport master (
    output i_start,
    output i_a,
    output i_b,
    input  o_bit_a,
    input  o_bit_b,
    output i_yamb,
    output i_yarb,
    output i_ya_wieksze_b,
    input  o_busy,
    input  o_done,
    input  o_yamb,
    input  o_yarb,
    input  o_ya_wieksze_b,
    input  o_err
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Bit-serial MSB-first magnitude comparator driving an external
// 1-bit comparator and resolving the word result with early exit.
module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input logic i_clk,
  input logic i_rst,
  serial_word_comparator_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             err_q, err_d;

  logic f_lt, f_eq, f_gt;
  logic flags_onehot;

  assign f_lt = bus.i_yamb;
  assign f_eq = bus.i_yarb;
  assign f_gt = bus.i_ya_wieksze_b;

  assign flags_onehot = ( f_lt & ~f_eq & ~f_gt)
                      | (~f_lt &  f_eq & ~f_gt)
                      | (~f_lt & ~f_eq &  f_gt);

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          sh_a_d  = bus.i_a;
          sh_b_d  = bus.i_b;
          cnt_d   = CW'(WIDTH - 1);
          err_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Flags come back combinationally from the bit pair we drive now.
        if (!flags_onehot) begin
          err_d   = 1'b1;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = DONE;
        end else if (f_lt || f_gt) begin
          lt_d    = f_lt;
          eq_d    = 1'b0;
          gt_d    = f_gt;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          state_d = DONE;
        end else begin
          sh_a_d = sh_a_q << 1;
          sh_b_d = sh_b_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_done         = (state_q == DONE);
  assign bus.o_bit_a        = (state_q == SHIFT) & sh_a_q[WIDTH-1];
  assign bus.o_bit_b        = (state_q == SHIFT) & sh_b_q[WIDTH-1];
  assign bus.o_yamb         = lt_q;
  assign bus.o_yarb         = eq_q;
  assign bus.o_ya_wieksze_b = gt_q;
  assign bus.o_err          = err_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator with a 1-bit comparator
// model in the loop and an override path for flag fault injection.
module tb_serial_word_comparator;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_word_comparator_if #(.WIDTH(W)) bus ();

  serial_word_comparator #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  logic ovr    = 1'b0;
  logic ovr_lt = 1'b0;
  logic ovr_eq = 1'b0;
  logic ovr_gt = 1'b0;

  assign bus.i_yamb = ovr ? ovr_lt
                    : (~bus.o_bit_a & bus.o_bit_b);
  assign bus.i_yarb = ovr ? ovr_eq
                    : (bus.o_bit_a ~^ bus.o_bit_b);
  assign bus.i_ya_wieksze_b = ovr ? ovr_gt
                    : (bus.o_bit_a & ~bus.o_bit_b);

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         lt;
    logic         eq;
    logic         gt;
    int           m;
  } vec_t;

  vec_t vt[8];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_start(input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_a     = W'($urandom);
    bus.i_b     = W'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input bit inject);
    int got;
    logic [W-1:0] rec_a, rec_b;
    logic [W-1:0] exp_a, exp_b;
    got   = 0;
    rec_a = '0;
    rec_b = '0;
    do_start(v.a, v.b);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (inject && c == 2) begin
        bus.i_start = 1'b1;
        bus.i_a     = 8'hFF;
        bus.i_b     = 8'h00;
      end
      if (inject && c == 3) bus.i_start = 1'b0;
      if (bus.o_done) begin
        got = c;
        break;
      end
      rec_a = {rec_a[W-2:0], bus.o_bit_a};
      rec_b = {rec_b[W-2:0], bus.o_bit_b};
    end
    bus.i_start = 1'b0;
    exp_a = v.a >> (W - v.m);
    exp_b = v.b >> (W - v.m);
    chk("done_cycle", got, v.m + 1);
    chk("busy_at_done", {31'b0, bus.o_busy}, 1);
    chk("result", {29'b0, bus.o_yamb, bus.o_yarb, bus.o_ya_wieksze_b},
        {29'b0, v.lt, v.eq, v.gt});
    chk("err_clear", {31'b0, bus.o_err}, 0);
    chk("bits_a", {24'b0, rec_a}, {24'b0, exp_a});
    chk("bits_b", {24'b0, rec_b}, {24'b0, exp_b});
    @(negedge clk);
    chk("idle_after", {30'b0, bus.o_busy, bus.o_done}, 0);
    chk("result_hold", {29'b0, bus.o_yamb, bus.o_yarb, bus.o_ya_wieksze_b},
        {29'b0, v.lt, v.eq, v.gt});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    logic seen;
    vec_t v4;

    vt[0] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8};
    vt[1] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
    vt[2] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 8};
    vt[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8};
    vt[4] = '{8'hFF, 8'hFE, 1'b0, 1'b0, 1'b1, 8};
    vt[5] = '{8'h40, 8'h80, 1'b1, 1'b0, 1'b0, 1};
    vt[6] = '{8'h10, 8'h08, 1'b0, 1'b0, 1'b1, 4};
    vt[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8};

    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {24'b0, bus.o_busy, bus.o_done, bus.o_yamb, bus.o_yarb,
         bus.o_ya_wieksze_b, bus.o_err, bus.o_bit_a, bus.o_bit_b}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i], 1'b0);

    // Second request during SHIFT must be ignored.
    v4 = '{8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 7};
    run_vec(v4, 1'b1);
    run_vec(vt[6], 1'b0);

    // Reset in the 4th SHIFT cycle aborts the compare.
    do_start(8'h3C, 8'h3C);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs",
        {24'b0, bus.o_busy, bus.o_done, bus.o_yamb, bus.o_yarb,
         bus.o_ya_wieksze_b, bus.o_err, bus.o_bit_a, bus.o_bit_b}, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | bus.o_done;
    end
    chk("no_done_after_abort", {31'b0, seen}, 0);
    run_vec(vt[0], 1'b0);

    // Non-one-hot flags in the first SHIFT cycle.
    ovr    = 1'b1;
    ovr_lt = 1'b1;
    ovr_eq = 1'b1;
    ovr_gt = 1'b0;
    do_start(8'h55, 8'h55);
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.o_done) begin
        got = c;
        break;
      end
    end
    chk("err_done_cycle", got, 2);
    chk("err_flag", {31'b0, bus.o_err}, 1);
    chk("err_results",
        {29'b0, bus.o_yamb, bus.o_yarb, bus.o_ya_wieksze_b}, 0);
    ovr = 1'b0;
    @(negedge clk);
    chk("err_hold", {31'b0, bus.o_err}, 1);
    run_vec(vt[2], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
